// File: rtl/booth_multiplier_8bit.sv
// Sequential signed 8x8 radix-2 Booth multiplier.
// One Booth step per clock through a shared 8-bit adder/subtractor.
// A 16-bit two's-complement product is delivered 9 cycles after an accepted start.

// 8-bit adder/subtractor: S = A + B when sel=0, S = A - B when sel=1.
// cout is the raw carry out of A + (B ^ {8{sel}}) + sel.
module adder_subtractor_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       sel,
  output logic [7:0] S,
  output logic       cout
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  assign b_eff = B ^ {8{sel}};
  assign sum   = {1'b0, A} + {1'b0, b_eff} + {8'd0, sel};
  assign S     = sum[7:0];
  assign cout  = sum[8];

endmodule

module booth_multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Architectural state.
  state_t      state_q, state_d;
  logic [7:0]  acc_q,   acc_d;
  logic [7:0]  q_q,     q_d;
  logic        q1_q,    q1_d;
  logic [7:0]  m_q,     m_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic [15:0] product_q, product_d;

  // Booth step datapath.
  logic [1:0]  booth_pair;
  logic        add_en;
  logic        adder_sel;
  logic [7:0]  adder_s;
  logic        adder_cout;
  logic [7:0]  r_val;
  logic        shift_in;
  logic [7:0]  acc_sh;
  logic [7:0]  q_sh;
  logic        q1_sh;

  // Pair {Q[0],Q_1}: 10 -> subtract M, 01 -> add M, 00/11 -> pass ACC.
  assign booth_pair = {q_q[0], q1_q};
  assign add_en     = q_q[0] ^ q1_q;
  assign adder_sel  = (booth_pair == 2'b10);

  adder_subtractor_8bit u_addsub (
    .A    (acc_q),
    .B    (m_q),
    .sel  (adder_sel),
    .S    (adder_s),
    .cout (adder_cout)
  );

  // Select the step result and form the arithmetic right shift of {R,Q,Q_1}.
  always_comb begin
    if (add_en) begin
      r_val = adder_s;
      // Ninth bit of the sign-extended sum, so M=-128 cannot overflow the shift.
      shift_in = m_q[7] ^ adder_sel ^ acc_q[7] ^ adder_cout;
    end else begin
      r_val    = acc_q;
      shift_in = acc_q[7];
    end
    acc_sh = {shift_in, r_val[7:1]};
    q_sh   = {r_val[0], q_q[7:1]};
    q1_sh  = q_q[0];
  end

  // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = 8'd0;
          q1_d    = 1'b0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          product_d = {acc_sh, q_sh};
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 8'd0;
      q_q       <= 8'd0;
      q1_q      <= 1'b0;
      m_q       <= 8'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
